bf_sequencer: RTL

//  Control sequencer that drives the 8-lane butterfly datapath from the polynomial RAM side.

---
 rtl/kyber_seq_pkg.sv | 31 +++
 rtl/bf_addr_gen.sv | 53 +++++
 rtl/bf_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kyber_seq_pkg.sv
// ============================================================================
// Module   : kyber_seq_pkg
// Purpose  : Shared encodings for the butterfly sequencer (modes, sizes, FSM).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package kyber_seq_pkg;

  localparam logic [1:0] MODE_NTT    = 2'd0;
  localparam logic [1:0] MODE_INTT   = 2'd1;
  localparam logic [1:0] MODE_MULT   = 2'd2;
  localparam logic [1:0] MODE_ADDSUB = 2'd3;

  localparam int N_WORDS  = 32;
  localparam int N_STAGES = 7;
  localparam int Q        = 3329;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_LDA   = 3'd4,
    ST_LDB   = 3'd5,
    ST_CALC  = 3'd6
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/bf_addr_gen.sv
// ============================================================================
// Module   : bf_addr_gen
// Purpose  : Combinational NTT/INTT walk: (mode, stage, k) -> RAM/ROM address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_addr_gen
  import kyber_seq_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [2:0] stage,
  input  logic [4:0] k,
  output logic [5:0] rd_addr,
  output logic [6:0] coef_addr,
  output logic       bf_type
);

  logic [2:0] w_es;
  logic [4:0] w_p;
  logic [4:0] w_d;
  logic [4:0] w_mask;
  logic [5:0] w_low;

  // INTT walks the NTT stages in reverse order
  assign w_es   = (mode == MODE_INTT) ? (3'(N_STAGES - 1) - stage) : stage;
  assign w_p    = {1'b0, k[4:1]};
  assign w_d    = 5'd16 >> w_es;
  assign w_mask = w_d - 5'd1;
  assign w_low  = {w_p & ~w_mask, 1'b0} | {1'b0, w_p & w_mask};

  always_comb begin
    rd_addr   = '0;
    coef_addr = '0;
    bf_type   = 1'b0;
    if (mode == MODE_NTT || mode == MODE_INTT) begin
      if (w_es <= 3'd4) begin
        rd_addr   = w_low + (k[0] ? {1'b0, w_d} : 6'd0);
        coef_addr = (7'd1 << w_es) + ({3'b000, k[4:1]} >> (3'd4 - w_es));
        bf_type   = k[0];
      end else if (w_es == 3'd5) begin
        rd_addr   = {1'b0, k};
        coef_addr = 7'd32 + {2'b00, k};
      end else begin
        rd_addr   = {1'b0, k};
        coef_addr = 7'd64 + {2'b00, k};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bf_sequencer.sv
// ============================================================================
// Module   : bf_sequencer
// Purpose  : Drives the 8-lane butterfly for NTT/INTT/MULT/ADDSUB passes.
//            Optional cycle counter port under macro BF_SEQ_CYCLE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_sequencer
  import kyber_seq_pkg::*;
#(
  parameter int NTT_LAT    = 7,
  parameter int MULT_LAT   = 10,
  parameter int ADDSUB_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [5:0] rd_addr,
  output logic [6:0] coef_addr,
  output logic [2:0] bf_stage,
  output logic       bf_type,
  output logic       bf_pre_load,
  output logic       bf_load,
  output logic       wr_en,
  output logic [5:0] wr_addr
`ifdef BF_SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0] cycle_cnt
`endif
);

  localparam int c_max_lat = (MULT_LAT > NTT_LAT)
                           ? ((MULT_LAT > ADDSUB_LAT) ? MULT_LAT : ADDSUB_LAT)
                           : ((NTT_LAT > ADDSUB_LAT) ? NTT_LAT : ADDSUB_LAT);
  localparam int c_depth   = c_max_lat + 1;
  localparam int c_cw      = $clog2(c_depth + 1);
  localparam logic [4:0] c_last_k     = 5'(N_WORDS - 1);
  localparam logic [2:0] c_last_stage = 3'(N_STAGES - 1);

  seq_state_t r_state, w_nxt_state;
  logic [1:0] r_mode, w_nxt_mode;
  logic [2:0] r_stage, w_nxt_stage;
  logic [4:0] r_k, w_nxt_k;
  logic [1:0] r_sub, w_nxt_sub;
  logic [c_cw-1:0] r_dcnt, w_nxt_dcnt;
  logic [c_cw-1:0] w_lat;

  logic       w_wordwise, w_last;
  logic [2:0] w_stage;
  logic       w_type, w_pre, w_load, w_iss;
  logic [5:0] w_iss_addr;

  logic [5:0] w_gen_rd;
  logic [6:0] w_gen_coef;
  logic       w_gen_type;

  logic [c_depth-1:0] r_dly_vld;
  logic [5:0]         r_dly_addr [c_depth];

  bf_addr_gen u_addr_gen (
    .mode      (r_mode),
    .stage     (r_stage),
    .k         (r_k),
    .rd_addr   (w_gen_rd),
    .coef_addr (w_gen_coef),
    .bf_type   (w_gen_type)
  );

  assign w_wordwise = (r_mode == MODE_MULT) || (r_mode == MODE_ADDSUB);

  always_comb begin
    w_lat = c_cw'(NTT_LAT);
    if (r_mode == MODE_MULT)        w_lat = c_cw'(MULT_LAT);
    else if (r_mode == MODE_ADDSUB) w_lat = c_cw'(ADDSUB_LAT);
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_mode  = r_mode;
    w_nxt_stage = r_stage;
    w_nxt_k     = r_k;
    w_nxt_sub   = r_sub;
    w_nxt_dcnt  = r_dcnt;
    busy        = 1'b0;
    done        = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    coef_addr   = '0;
    w_stage     = '0;
    w_type      = 1'b0;
    w_pre       = 1'b0;
    w_load      = 1'b0;
    w_iss       = 1'b0;
    w_iss_addr  = '0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nxt_mode  = mode;
          w_nxt_stage = '0;
          w_nxt_k     = '0;
          w_nxt_sub   = '0;
          w_nxt_dcnt  = '0;
          w_nxt_state = (mode == MODE_MULT || mode == MODE_ADDSUB) ? ST_LDA : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy       = 1'b1;
        rd_en      = 1'b1;
        rd_addr    = w_gen_rd;
        coef_addr  = w_gen_coef;
        w_stage    = r_stage;
        w_type     = w_gen_type;
        // consecutive reads pair up in the butterfly input buffer
        w_pre      = ~r_k[0];
        w_load     = r_k[0];
        w_iss      = 1'b1;
        w_iss_addr = w_gen_rd;
        if (r_k == c_last_k) begin
          w_nxt_k     = '0;
          w_nxt_dcnt  = '0;
          w_nxt_state = ST_DRAIN;
        end else begin
          w_nxt_k = r_k + 5'd1;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // hold off the next pass until the last write of this one has landed
        if (r_dcnt == w_lat) begin
          if (w_wordwise || r_stage == c_last_stage) begin
            w_nxt_state = ST_DONE;
          end else begin
            w_nxt_stage = r_stage + 3'd1;
            w_nxt_state = ST_ISSUE;
          end
        end else begin
          w_nxt_dcnt = r_dcnt + c_cw'(1);
        end
      end
      ST_LDA: begin
        busy        = 1'b1;
        rd_en       = 1'b1;
        rd_addr     = {1'b0, r_k};
        w_pre       = 1'b1;
        w_nxt_state = ST_LDB;
      end
      ST_LDB: begin
        busy        = 1'b1;
        rd_en       = 1'b1;
        rd_addr     = {1'b1, r_k};
        w_load      = 1'b1;
        w_nxt_sub   = '0;
        w_nxt_state = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (r_mode == MODE_MULT) begin
          w_stage   = {1'b0, r_sub ^ 2'd2};
          coef_addr = 7'd64 + {3'b000, r_k[4:1]};
          w_last    = (r_sub == 2'd3);
        end else begin
          w_stage = {1'b0, r_sub};
          w_last  = (r_sub == 2'd1);
        end
        if (w_last) begin
          w_iss      = 1'b1;
          w_iss_addr = {1'b0, r_k};
          w_nxt_sub  = '0;
          if (r_k == c_last_k) begin
            w_nxt_k     = '0;
            w_nxt_dcnt  = '0;
            w_nxt_state = ST_DRAIN;
          end else begin
            w_nxt_k     = r_k + 5'd1;
            w_nxt_state = ST_LDA;
          end
        end else begin
          w_nxt_sub = r_sub + 2'd1;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_nxt_state = ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_stage     <= '0;
      r_k         <= '0;
      r_sub       <= '0;
      r_dcnt      <= '0;
      bf_stage    <= '0;
      bf_type     <= 1'b0;
      bf_pre_load <= 1'b0;
      bf_load     <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_mode      <= w_nxt_mode;
      r_stage     <= w_nxt_stage;
      r_k         <= w_nxt_k;
      r_sub       <= w_nxt_sub;
      r_dcnt      <= w_nxt_dcnt;
      bf_stage    <= w_stage;
      bf_type     <= w_type;
      bf_pre_load <= w_pre;
      bf_load     <= w_load;
    end
  end

  // tap index LAT is exactly 1+LAT cycles after the issue cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly_vld <= '0;
      for (int i = 0; i < c_depth; i++) r_dly_addr[i] <= '0;
    end else begin
      r_dly_vld     <= {r_dly_vld[c_depth-2:0], w_iss};
      r_dly_addr[0] <= w_iss_addr;
      for (int i = 1; i < c_depth; i++) r_dly_addr[i] <= r_dly_addr[i-1];
    end
  end

  assign wr_en   = r_dly_vld[w_lat];
  assign wr_addr = wr_en ? r_dly_addr[w_lat] : 6'd0;

`ifdef BF_SEQ_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (r_state == ST_IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy && cycle_cnt != 16'hFFFF) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
